// File: rtl/approx_adder_error_monitor_pkg.sv
// rtl/approx_adder_error_monitor_pkg.sv - shared state type and width helpers for the approximate-adder error monitor
package approx_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int err_w(input int width);
        return width + 2;
    endfunction

    function automatic int sq_w(input int width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/approx_adder_error_monitor_if.sv
// rtl/approx_adder_error_monitor_if.sv - sample stream (a, b, approximate sum) with valid/ready handshake
interface approx_adder_error_monitor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH:0]   in_sum;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_sum,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_sum,
        output in_ready
    );
endinterface

// File: rtl/approx_adder_error_monitor_err_calc.sv
// rtl/approx_adder_error_monitor_err_calc.sv - combinational first-stage datapath: exact sum, signed error, magnitude, nonzero flag
module approx_err_calc
    import approx_mon_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [WIDTH:0]             sum,
    output logic [err_w(WIDTH)-1:0]    err,
    output logic [WIDTH:0]             abs_err,
    output logic                       nonzero
);
    localparam int EW = err_w(WIDTH);

    logic [WIDTH:0] exact;

    assign exact   = {1'b0, a} + {1'b0, b};
    assign err     = {1'b0, sum} - {1'b0, exact};
    // Largest magnitude is 2^(WIDTH+1)-1, so the sign bit is never needed in abs_err
    assign abs_err = err[EW-1] ? (WIDTH+1)'(-err) : (WIDTH+1)'(err);
    assign nonzero = |err;

endmodule

// File: rtl/approx_adder_error_monitor.sv
// rtl/approx_adder_error_monitor.sv - streaming error statistics (count, signed sum, squared sum, max) for approximate adders
module approx_adder_error_monitor
    import approx_mon_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 17,
    parameter int ACC_W = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CNT_W-1:0]              num_samples,
    approx_adder_error_monitor_if.slave   samp,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              err_count,
    output logic [WIDTH:0]                max_abs_err,
    output logic [ACC_W-1:0]              sum_err,
    output logic [ACC_W-1:0]              sum_sq_err,
    output logic                          overflow
);
    localparam int EW = err_w(WIDTH);
    localparam int SW = sq_w(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             ready_q;
    logic             xfer;
    logic             start_ok;

    logic [EW-1:0]    c_err;
    logic [WIDTH:0]   c_abs;
    logic             c_nz;

    logic             s1_valid;
    logic [EW-1:0]    s1_err;
    logic [WIDTH:0]   s1_abs;
    logic             s1_nz;

    logic [SW-1:0]    sq;
    logic [ACC_W:0]   se_next;
    logic [ACC_W:0]   sq_next;
    logic             se_ovf;
    logic [ACC_W-1:0] se_sat;

    assign samp.in_ready = ready_q;
    assign xfer          = samp.in_valid && ready_q;
    assign start_ok      = start && (state == IDLE || state == DONE);

    approx_err_calc #(.WIDTH(WIDTH)) u_err_calc (
        .a       (samp.in_a),
        .b       (samp.in_b),
        .sum     (samp.in_sum),
        .err     (c_err),
        .abs_err (c_abs),
        .nonzero (c_nz)
    );

    // One guard bit on each accumulator exposes overflow for saturation
    assign sq      = SW'(s1_abs) * SW'(s1_abs);
    assign se_next = {sum_err[ACC_W-1], sum_err} + {{(ACC_W+1-EW){s1_err[EW-1]}}, s1_err};
    assign sq_next = {1'b0, sum_sq_err} + {{(ACC_W+1-SW){1'b0}}, sq};
    assign se_ovf  = se_next[ACC_W] != se_next[ACC_W-1];
    assign se_sat  = se_next[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            ready_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        remaining <= num_samples;
                        if (num_samples == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state   <= DRAIN;
                            ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // s1 empty here means the final sample has already reached the accumulators
                    if (!s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_err      <= '0;
            s1_abs      <= '0;
            s1_nz       <= 1'b0;
            err_count   <= '0;
            max_abs_err <= '0;
            sum_err     <= '0;
            sum_sq_err  <= '0;
            overflow    <= 1'b0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_err <= c_err;
                s1_abs <= c_abs;
                s1_nz  <= c_nz;
            end
            if (start_ok) begin
                err_count   <= '0;
                max_abs_err <= '0;
                sum_err     <= '0;
                sum_sq_err  <= '0;
                overflow    <= 1'b0;
            end else if (s1_valid) begin
                if (s1_nz) begin
                    err_count <= err_count + CNT_W'(1);
                end
                if (s1_abs > max_abs_err) begin
                    max_abs_err <= s1_abs;
                end
                sum_err    <= se_ovf ? se_sat : se_next[ACC_W-1:0];
                sum_sq_err <= sq_next[ACC_W] ? '1 : sq_next[ACC_W-1:0];
                if (se_ovf || sq_next[ACC_W]) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// tb/tb_approx_adder_error_monitor.sv - randomized self-checking bench with behavioural statistics model
module tb_approx_adder_error_monitor;
    localparam int WIDTH = 8;
    localparam int CNT_W = 17;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;

    always #5 clk = ~clk;

    approx_adder_error_monitor_if #(.WIDTH(WIDTH)) samp_l ();
    approx_adder_error_monitor_if #(.WIDTH(WIDTH)) samp_s ();

    assign samp_s.in_valid = samp_l.in_valid;
    assign samp_s.in_a     = samp_l.in_a;
    assign samp_s.in_b     = samp_l.in_b;
    assign samp_s.in_sum   = samp_l.in_sum;

    logic             busy_l, done_l, ovf_l;
    logic [CNT_W-1:0] cnt_l;
    logic [WIDTH:0]   max_l;
    logic [47:0]      se_l, sq_l;
    logic             busy_s, done_s, ovf_s;
    logic [CNT_W-1:0] cnt_s;
    logic [WIDTH:0]   max_s;
    logic [19:0]      se_s, sq_s;

    approx_adder_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(48)) dut_l (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .samp(samp_l),
        .busy(busy_l), .done(done_l), .err_count(cnt_l), .max_abs_err(max_l),
        .sum_err(se_l), .sum_sq_err(sq_l), .overflow(ovf_l)
    );

    approx_adder_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(20)) dut_s (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .samp(samp_s),
        .busy(busy_s), .done(done_s), .err_count(cnt_s), .max_abs_err(max_s),
        .sum_err(se_s), .sum_sq_err(sq_s), .overflow(ovf_s)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: edge-counted view of run progress and statistics per accumulator width
    typedef struct { int e; int err; } pend_t;
    pend_t  pq[$];
    int     cur = 0;
    bit     m_active, m_ready, m_busy, m_done, m_xfer;
    int     m_n, m_acc, m_last;
    longint m_cnt, m_max;
    longint m_se [2];
    longint m_sq [2];
    bit     m_ovf [2];
    int     acc_w [2] = '{48, 20};

    function automatic void clear_stats();
        m_cnt = 0;
        m_max = 0;
        for (int w = 0; w < 2; w++) begin
            m_se[w]  = 0;
            m_sq[w]  = 0;
            m_ovf[w] = 1'b0;
        end
    endfunction

    function automatic void fold(input int err);
        longint lim, top, se, sq, mag;
        mag = (err < 0) ? -err : err;
        if (err != 0) m_cnt++;
        if (mag > m_max) m_max = mag;
        for (int w = 0; w < 2; w++) begin
            lim = longint'(1) << (acc_w[w] - 1);
            top = (longint'(1) << acc_w[w]) - 1;
            se  = m_se[w] + err;
            if (se > lim - 1) begin se = lim - 1; m_ovf[w] = 1'b1; end
            if (se < -lim)    begin se = -lim;    m_ovf[w] = 1'b1; end
            m_se[w] = se;
            sq = m_sq[w] + mag * mag;
            if (sq > top) begin sq = top; m_ovf[w] = 1'b1; end
            m_sq[w] = sq;
        end
    endfunction

    always @(posedge clk) begin
        cur++;
        m_xfer = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_n = 0;
            m_acc = 0;
            m_last = 0;
            pq.delete();
            clear_stats();
        end else begin
            while (pq.size() > 0 && pq[0].e <= cur - 1) begin
                fold(pq[0].err);
                void'(pq.pop_front());
            end
            if (samp_l.in_valid && m_ready) begin
                pq.push_back('{cur, int'(samp_l.in_sum) - int'(samp_l.in_a) - int'(samp_l.in_b)});
                m_acc++;
                m_last = cur;
                m_xfer = 1'b1;
            end
            if (start && !m_busy) begin
                clear_stats();
                pq.delete();
                m_active = 1'b1;
                m_n = int'(num_samples);
                m_acc = 0;
                m_last = cur - 2;
            end
        end
        m_ready = m_active && (m_acc < m_n);
        m_done  = m_active && (m_acc == m_n) && (cur >= m_last + 2);
        m_busy  = m_active && !m_done;
    end

    always @(negedge clk) begin
        chk("in_ready_l", samp_l.in_ready, m_ready);
        chk("in_ready_s", samp_s.in_ready, m_ready);
        chk("busy_l", busy_l, m_busy);
        chk("busy_s", busy_s, m_busy);
        chk("done_l", done_l, m_done);
        chk("done_s", done_s, m_done);
        chk("err_count_l", cnt_l, m_cnt);
        chk("err_count_s", cnt_s, m_cnt);
        chk("max_abs_err_l", max_l, m_max);
        chk("max_abs_err_s", max_s, m_max);
        chk("sum_err_l", longint'($signed(se_l)), m_se[0]);
        chk("sum_err_s", longint'($signed(se_s)), m_se[1]);
        chk("sum_sq_err_l", longint'(sq_l), m_sq[0]);
        chk("sum_sq_err_s", longint'(sq_s), m_sq[1]);
        chk("overflow_l", ovf_l, m_ovf[0]);
        chk("overflow_s", ovf_s, m_ovf[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_samples = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int s);
        int budget;
        budget = 50;
        samp_l.in_valid = 1'b1;
        samp_l.in_a     = WIDTH'(a);
        samp_l.in_b     = WIDTH'(b);
        samp_l.in_sum   = (WIDTH+1)'(s);
        do begin
            tick();
            budget--;
        end while (!m_xfer && budget > 0);
        if (!m_xfer) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: no transfer within 50 cycles at %0t", $time);
        end
        samp_l.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int budget;
        budget = 40;
        while (!done_l && budget > 0) begin
            tick();
            budget--;
        end
        chk(name, done_l, 1);
    endtask

    int r_sum;

    initial begin
        samp_l.in_valid = 1'b0;
        samp_l.in_a     = '0;
        samp_l.in_b     = '0;
        samp_l.in_sum   = '0;
        tick();
        tick();
        chk("reset_done", done_l, 0);
        chk("reset_ready", samp_l.in_ready, 0);
        rst = 1'b0;
        tick();

        // Exhaustive exact adder
        do_start(65536);
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++)
                send(a, b, a + b);
        wait_done("exh_done");
        chk("exh_err_count", cnt_l, 0);
        chk("exh_sum_err", longint'($signed(se_l)), 0);
        chk("exh_sum_sq", longint'(sq_l), 0);
        chk("exh_max", max_l, 0);

        // Single sample, done three cycles after the transfer
        do_start(1);
        send(3, 0, 4);
        chk("single_done_early", done_l, 0);
        tick();
        chk("single_done_t2", done_l, 0);
        tick();
        chk("single_done_t3", done_l, 1);
        chk("single_count", cnt_l, 1);
        chk("single_sum_err", longint'($signed(se_l)), 1);
        chk("single_sum_sq", longint'(sq_l), 1);
        chk("single_max", max_l, 1);

        // Extreme errors of both signs
        do_start(2);
        send(255, 255, 0);
        send(0, 0, 511);
        wait_done("ext_done");
        chk("ext_sum_err", longint'($signed(se_l)), 1);
        chk("ext_sum_sq", longint'(sq_l), 521221);
        chk("ext_max", max_l, 511);
        chk("ext_count", cnt_l, 2);

        // Random gaps, start ignored during drain, in_valid held high after the last accept
        do_start(5);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 511));
        end
        samp_l.in_valid = 1'b1;
        start = 1'b1;
        num_samples = CNT_W'(3);
        tick();
        start = 1'b0;
        chk("drain_ready", samp_l.in_ready, 0);
        wait_done("gap_done");
        samp_l.in_valid = 1'b0;
        chk("gap_transfers", m_acc, 5);

        // Longer random run mixing exact and approximate results
        do_start(40);
        for (int i = 0; i < 40; i++) begin
            int a, b;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            r_sum = ($urandom_range(0, 1) == 1) ? a + b : int'($urandom_range(0, 511));
            repeat ($urandom_range(0, 2)) tick();
            send(a, b, r_sum);
        end
        wait_done("rand_done");

        // Saturation of the narrow squared accumulator
        do_start(5);
        for (int i = 0; i < 5; i++) send(0, 0, 511);
        wait_done("sat_done");
        chk("sat_sq_s", longint'(sq_s), 64'hFFFFF);
        chk("sat_ovf_s", ovf_s, 1);
        chk("sat_sq_l", longint'(sq_l), 1305605);
        chk("sat_ovf_l", ovf_l, 0);
        chk("sat_se_s", longint'($signed(se_s)), 2555);

        // Reset in the middle of a run
        do_start(10);
        send(1, 1, 7);
        send(2, 2, 0);
        send(9, 9, 18);
        rst = 1'b1;
        tick();
        chk("rst_count", cnt_l, 0);
        chk("rst_sum_sq", longint'(sq_l), 0);
        chk("rst_busy", busy_l, 0);
        chk("rst_ready", samp_l.in_ready, 0);
        chk("rst_ovf_s", ovf_s, 0);
        rst = 1'b0;
        tick();

        // Zero-length run
        do_start(0);
        chk("zero_done", done_l, 1);
        chk("zero_count", cnt_l, 0);
        chk("zero_busy", busy_l, 0);
        tick();
        tick();
        chk("zero_done_hold", done_l, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
